// File: rtl/fetch_queue_pkg.sv
// Shared widths, entry layout and depth default for the fetch queue.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue bypass path).
package fetch_queue_pkg;

  localparam int INSTR_LEN = 32;
  localparam int WORD      = 32;
  localparam int FQ_DEPTH  = 4;
  localparam int FQ_PTR_W  = $clog2(FQ_DEPTH);

  // One queue slot: the fetched PC and its instruction word.
  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [INSTR_LEN-1:0] instr;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle. The queue uses the slave modport,
// the producer/consumer side (fetch, decode, redirect) uses master.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int PTR_W = FQ_PTR_W
) ();

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_LEN-1:0] in_instr;
  logic [WORD-1:0]      in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_LEN-1:0] out_instr;
  logic [WORD-1:0]      out_pc;
  logic [PTR_W:0]       level;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, level
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, level
  );

endinterface

// File: rtl/fetch_queue_storage.sv
// fq_storage: DEPTH-entry register array, one synchronous write port and
// one combinational read port so the head entry is visible without delay.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fq_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output fq_entry_t        rdata
);

  // Contents are deliberately not reset; only the queue pointers are.
  fq_entry_t mem_q [DEPTH];

  // Write the accepted entry into its slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO decoupling fetch from decode, with flush on redirect.
// Holds read/write pointers, the occupancy counter and handshake logic.
// Define FETCH_QUEUE_BYPASS_EN to let an entry arriving at an empty queue
// reach decode in the same cycle without being stored.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  fq
);

  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;

  logic      empty;
  logic      full;
  logic      bypass;
  logic      push;
  logic      pop;
  fq_entry_t wr_entry;
  fq_entry_t rd_entry;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue and decode ready: hand the incoming entry straight through.
  assign bypass = reset && empty && fq.in_valid && fq.out_ready && !fq.flush;
`else
  assign bypass = 1'b0;
`endif

  // Ready/valid derive from registered occupancy only; a pop never frees
  // a slot for a push in the same cycle.
  assign fq.in_ready  = !full && !fq.flush;
  assign fq.out_valid = bypass || (!empty && !fq.flush);
  assign fq.level     = level_q;

  // A bypassed entry is consumed directly and never touches storage.
  assign push = fq.in_valid && fq.in_ready && !bypass;
  assign pop  = fq.out_valid && fq.out_ready && !bypass;

  assign wr_entry = '{pc: fq.in_pc, instr: fq.in_instr};

  fq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Output mux: bypass entry, stored head, or an all-zero NOP bubble.
  always_comb begin
    fq.out_pc    = '0;
    fq.out_instr = '0;
    if (bypass) begin
      fq.out_pc    = fq.in_pc;
      fq.out_instr = fq.in_instr;
    end else if (fq.out_valid) begin
      fq.out_pc    = rd_entry.pc;
      fq.out_instr = rd_entry.instr;
    end
  end

  // Next pointers and occupancy; a flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (fq.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked
// every cycle against a queue-based model. Honours FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = FQ_DEPTH;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fetch_queue_if fq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  bit          chk_on = 1'b0;
  bit [63:0]   mq[$];        // model contents: {pc, instr}, head at index 0
  logic [31:0] pop_log[$];   // pcs actually handed to decode

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Apply inputs just after an edge; return before the following negedge.
  task automatic set_in(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    fq.flush     = fl;
    fq.in_valid  = iv;
    fq.in_pc     = pc;
    fq.in_instr  = $urandom;
    fq.out_ready = ordy;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO of entries, updated at each edge from the rules.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset || fq.flush) begin
      mq.delete();
    end else if (!(BYP && mq.size() == 0 && fq.in_valid && fq.out_ready)) begin
      bit do_pop;
      bit do_push;
      do_pop  = (mq.size() > 0) && fq.out_ready;
      do_push = (mq.size() < DEPTH) && fq.in_valid;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({fq.in_pc, fq.in_instr});
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      bit        byp;
      bit        ev;
      logic [63:0] hd;
      byp = BYP && reset && mq.size() == 0 && fq.in_valid && fq.out_ready && !fq.flush;
      ev  = byp || (mq.size() > 0 && !fq.flush);
      hd  = byp ? {fq.in_pc, fq.in_instr} : (ev ? mq[0] : 64'h0);
      chk("level", 64'(fq.level), 64'(mq.size()));
      chk("out_valid", 64'(fq.out_valid), 64'(ev));
      chk("out_pc", 64'(fq.out_pc), 64'(hd[63:32]));
      chk("out_instr", 64'(fq.out_instr), 64'(hd[31:0]));
      if (reset) chk("in_ready", 64'(fq.in_ready), 64'(mq.size() < DEPTH && !fq.flush));
      if (fq.out_valid && fq.out_ready) begin
        pop_log.push_back(fq.out_pc);
        $display("pop  pc=%h instr=%h level=%0d", fq.out_pc, fq.out_instr, fq.level);
      end
    end
  end

  initial begin
    fq.flush = 1'b0; fq.in_valid = 1'b0; fq.in_pc = '0; fq.in_instr = '0; fq.out_ready = 1'b0;
    chk_on = 1'b1;

    // 1. reset held two cycles, then idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    set_in(0, 0, 0, 0);
    chk("t1_level", 64'(fq.level), 64'd0);
    chk("t1_out_valid", 64'(fq.out_valid), 64'd0);
    chk("t1_in_ready", 64'(fq.in_ready), 64'd1);
    chk("t1_out_instr", 64'(fq.out_instr), 64'd0);
    tick();

    // 2. fill to DEPTH with decode stalled; fifth push refused
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 32'(4 * i), 0);
      tick();
    end
    set_in(0, 1, 32'd16, 0);
    chk("t2_level", 64'(fq.level), 64'd4);
    chk("t2_in_ready", 64'(fq.in_ready), 64'd0);
    chk("t2_head_pc", 64'(fq.out_pc), 64'd0);
    tick();
    set_in(0, 0, 0, 0);
    chk("t2_level_after", 64'(fq.level), 64'd4);
    tick();

    // 3. drain in order
    pop_log.delete();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1);
      tick();
    end
    set_in(0, 0, 0, 1);
    chk("t3_out_valid", 64'(fq.out_valid), 64'd0);
    chk("t3_level", 64'(fq.level), 64'd0);
    chk("t3_count", 64'(pop_log.size()), 64'd4);
    for (int j = 0; j < 4; j++)
      chk("t3_order", 64'((j < pop_log.size()) ? pop_log[j] : 32'hdead_beef), 64'(4 * j));
    tick();

    // 4. streaming push+pop at level 2 across pointer wrap
    set_in(0, 1, 32'h100, 0); tick();
    set_in(0, 1, 32'h104, 0); tick();
    pop_log.delete();
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1, 32'h108 + 32'(4 * i), 1);
      chk("t4_level", 64'(fq.level), 64'd2);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 1);
      tick();
    end
    set_in(0, 0, 0, 0);
    chk("t4_count", 64'(pop_log.size()), 64'd12);
    for (int j = 0; j < 12; j++)
      chk("t4_order", 64'((j < pop_log.size()) ? pop_log[j] : 32'hdead_beef), 64'(32'h100 + 32'(4 * j)));
    tick();

    // 5. flush with level 3 and an entry on the input
    set_in(0, 1, 32'h20, 0); tick();
    set_in(0, 1, 32'h24, 0); tick();
    set_in(0, 1, 32'h28, 0); tick();
    pop_log.delete();
    set_in(1, 1, 32'h40, 1);
    chk("t5_in_ready", 64'(fq.in_ready), 64'd0);
    chk("t5_out_valid", 64'(fq.out_valid), 64'd0);
    chk("t5_out_pc", 64'(fq.out_pc), 64'd0);
    tick();
    set_in(1, 1, 32'h44, 1);
    chk("t5_level_hold", 64'(fq.level), 64'd0);
    tick();
    set_in(0, 0, 0, 1);
    chk("t5_level", 64'(fq.level), 64'd0);
    chk("t5_out_valid2", 64'(fq.out_valid), 64'd0);
    tick();
    chk("t5_no_emit", 64'(pop_log.size()), 64'd0);

    // 6. asynchronous reset between edges at level 2
    set_in(0, 1, 32'h60, 0); tick();
    set_in(0, 1, 32'h64, 0); tick();
    set_in(0, 0, 0, 0);
    chk("t6_level_pre", 64'(fq.level), 64'd2);
    reset = 1'b0;
    #1;
    chk("t6_out_valid", 64'(fq.out_valid), 64'd0);
    chk("t6_level", 64'(fq.level), 64'd0);
    chk("t6_out_pc", 64'(fq.out_pc), 64'd0);
    tick();
    tick();
    reset = 1'b1;

    // 6b. empty-queue latency (zero with bypass, one without)
    pop_log.delete();
    set_in(0, 1, 32'h80, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("t6_byp_valid", 64'(fq.out_valid), 64'd1);
    chk("t6_byp_pc", 64'(fq.out_pc), 64'h80);
    chk("t6_byp_level", 64'(fq.level), 64'd0);
    tick();
    set_in(0, 0, 0, 1);
    chk("t6_byp_level2", 64'(fq.level), 64'd0);
    chk("t6_byp_valid2", 64'(fq.out_valid), 64'd0);
`else
    chk("t6_lat_valid", 64'(fq.out_valid), 64'd0);
    tick();
    set_in(0, 0, 0, 1);
    chk("t6_lat_valid2", 64'(fq.out_valid), 64'd1);
    chk("t6_lat_pc", 64'(fq.out_pc), 64'h80);
`endif
    tick();
    chk("t6_emit_count", 64'(pop_log.size()), 64'd1);

    // random traffic, model-checked every cycle
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom % 16) == 0, ($urandom % 3) != 0, $urandom, ($urandom % 3) != 0);
      tick();
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
